// File: rtl/mac_checker_pkg.sv
// mac_pkg: shared state encoding, result width and golden multiply for mac_checker.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MAX_DW = 32;

    function automatic int res_w(input int dw);
        return 2 * dw + 1;
    endfunction

    // Operands arrive zero-padded to MAX_DW; the low dw bits are extended to a
    // common signed width so the low 2*dw+1 product bits are exact.
    function automatic logic [2*MAX_DW:0] golden(
        input logic [MAX_DW-1:0] a,
        input logic [MAX_DW-1:0] w,
        input logic              as,
        input logic              ws,
        input int                dw
    );
        logic        [2*MAX_DW+1:0] m;
        logic signed [2*MAX_DW+1:0] ae;
        logic signed [2*MAX_DW+1:0] we;
        logic signed [2*MAX_DW+1:0] p;
        m  = {(2*MAX_DW+2){1'b1}} << dw;
        ae = (as && a[dw-1]) ? $signed({{(MAX_DW+2){1'b0}}, a} | m) : $signed({{(MAX_DW+2){1'b0}}, a} & ~m);
        we = (ws && w[dw-1]) ? $signed({{(MAX_DW+2){1'b0}}, w} | m) : $signed({{(MAX_DW+2){1'b0}}, w} & ~m);
        p  = ae * we;
        return p[2*MAX_DW:0];
    endfunction

endpackage

// File: rtl/mac_checker_if.sv
// mac_checker_if: operand/result bus observed between the stimulus driver and the MAC under test.
interface mac_checker_if #(parameter int DW = 8);

    logic          in_valid;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_w;
    logic          in_asigned;
    logic          in_wsigned;
    logic [2*DW:0] dut_q;

    modport master (output in_valid, in_a, in_w, in_asigned, in_wsigned, dut_q);
    modport slave  (input  in_valid, in_a, in_w, in_asigned, in_wsigned, dut_q);

endinterface

// File: rtl/mac_chk_delay.sv
// mac_chk_delay: LAT-stage valid/data delay line aligning accepted operands with the DUT result.
module mac_chk_delay #(
    parameter int LAT = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);

    logic [LAT-1:0] v_q;
    logic [W-1:0]   d_q [LAT];

    // Valid bits shift every cycle and are flushed on reset or when a run starts.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            v_q <= '0;
        end else begin
            v_q[0] <= v_i;
            for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
        end
    end

    // Payload follows the valid bits; it is only meaningful where valid is set.
    always_ff @(posedge clk) begin
        d_q[0] <= d_i;
        for (int i = 1; i < LAT; i++) d_q[i] <= d_q[i-1];
    end

    assign v_o = v_q[LAT-1];
    assign d_o = d_q[LAT-1];

endmodule

// File: rtl/mac_checker.sv
// mac_checker: compares a MAC's results against a golden product over NUM operand pairs.
// Optional first-mismatch capture is built when MAC_CHK_CAPTURE_EN is defined.
module mac_checker
    import mac_pkg::*;
#(
    parameter int          DW  = 8,
    parameter int          LAT = 1,
    parameter int unsigned NUM = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    mac_checker_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   chk_cnt,
    output logic [15:0]   err_cnt,
    output logic          cap_valid,
    output logic [DW-1:0] cap_a,
    output logic [DW-1:0] cap_w,
    output logic [2*DW:0] cap_exp,
    output logic [2*DW:0] cap_act
);

    localparam int RW = res_w(DW);
    localparam int PW = 2 * DW + 2;

    state_e        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   chk_q, chk_d;
    logic [15:0]   err_q, err_d;
    logic          busy_q, done_q, pass_q;
    logic          go, take, dv, mis;
    logic [PW-1:0] dd;
    logic [DW-1:0] dl_a, dl_w;
    logic          dl_as, dl_ws;
    logic [RW-1:0] gold;

    assign go   = start && (state_q == IDLE || state_q == DONE);
    assign take = (state_q == RUN) && bus.in_valid;

    mac_chk_delay #(.LAT(LAT), .W(PW)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .v_i   (take),
        .d_i   ({bus.in_asigned, bus.in_wsigned, bus.in_a, bus.in_w}),
        .v_o   (dv),
        .d_o   (dd)
    );

    assign {dl_as, dl_ws, dl_a, dl_w} = dd;
    assign gold = RW'(golden(MAX_DW'(dl_a), MAX_DW'(dl_w), dl_as, dl_ws, DW));
    assign mis  = dv && (gold != bus.dut_q);

    // Next state and run counters; a taken start wins over everything else.
    always_comb begin
        state_d = go                                                  ? RUN   :
                  (state_q == RUN   && take && acc_q == 32'(NUM - 1)) ? DRAIN :
                  (state_q == DRAIN && dv   && chk_q == 32'(NUM - 1)) ? DONE  : state_q;
        acc_d   = go ? '0 : acc_q + 32'(take);
        chk_d   = go ? '0 : chk_q + 32'(dv);
        err_d   = go ? '0 : err_q + 16'(mis && err_q != 16'hFFFF);
    end

    // State, counters and status flags; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= state_d == DONE;
            pass_q  <= (state_d == DONE) && (err_d == '0);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign chk_cnt = chk_q;
    assign err_cnt = err_q;

`ifdef MAC_CHK_CAPTURE_EN
    logic          cap_v_q;
    logic [DW-1:0] cap_a_q, cap_w_q;
    logic [RW-1:0] cap_e_q, cap_c_q;

    // Hold the first mismatch of the run; later mismatches leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n || go) begin
            cap_v_q <= 1'b0;
            cap_a_q <= '0;
            cap_w_q <= '0;
            cap_e_q <= '0;
            cap_c_q <= '0;
        end else if (mis && !cap_v_q) begin
            cap_v_q <= 1'b1;
            cap_a_q <= dl_a;
            cap_w_q <= dl_w;
            cap_e_q <= gold;
            cap_c_q <= bus.dut_q;
        end
    end

    assign cap_valid = cap_v_q;
    assign cap_a     = cap_a_q;
    assign cap_w     = cap_w_q;
    assign cap_exp   = cap_e_q;
    assign cap_act   = cap_c_q;
`else
    assign cap_valid = 1'b0;
    assign cap_a     = '0;
    assign cap_w     = '0;
    assign cap_exp   = '0;
    assign cap_act   = '0;
`endif

endmodule

// File: tb/tb_mac_checker.sv
// tb_mac_checker: randomized and directed checks of two mac_checker builds (LAT=1/NUM=4, LAT=3/NUM=5)
// against a timestamp-based reference model of accepts and compares.
module tb_mac_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        st[2], vld[2], sa[2], sw[2];
    logic [7:0]  a[2], w[2];
    logic [16:0] dq[2];

    logic        busy[2], done[2], pass[2], capv[2];
    logic [31:0] chk[2];
    logic [15:0] err[2];
    logic [7:0]  capa[2], capw[2];
    logic [16:0] cape[2], capc[2];

    int checks = 0;
    int fails = 0;
    int e = 0;

    bit          run_on[2];
    int          acc_n[2], last_e[2], pct[2];
    bit          force_q[2];
    logic [16:0] force_v[2];
    int          qe[2][$];
    logic [16:0] qx[2][$], qr[2][$];
    logic [7:0]  qa[2][$], qw[2][$];

    always #5 clk = ~clk;

    mac_checker_if #(.DW(8)) bus0 ();
    mac_checker_if #(.DW(8)) bus1 ();

    assign bus0.in_valid   = vld[0];
    assign bus0.in_a       = a[0];
    assign bus0.in_w       = w[0];
    assign bus0.in_asigned = sa[0];
    assign bus0.in_wsigned = sw[0];
    assign bus0.dut_q      = dq[0];
    assign bus1.in_valid   = vld[1];
    assign bus1.in_a       = a[1];
    assign bus1.in_w       = w[1];
    assign bus1.in_asigned = sa[1];
    assign bus1.in_wsigned = sw[1];
    assign bus1.dut_q      = dq[1];

    mac_checker #(.DW(8), .LAT(1), .NUM(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bus(bus0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .chk_cnt(chk[0]), .err_cnt(err[0]),
        .cap_valid(capv[0]), .cap_a(capa[0]), .cap_w(capw[0]),
        .cap_exp(cape[0]), .cap_act(capc[0])
    );

    mac_checker #(.DW(8), .LAT(3), .NUM(5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bus(bus1),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .chk_cnt(chk[1]), .err_cnt(err[1]),
        .cap_valid(capv[1]), .cap_a(capa[1]), .cap_w(capw[1]),
        .cap_exp(cape[1]), .cap_act(capc[1])
    );

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic int num_of(input int k);
        return k == 0 ? 4 : 5;
    endfunction

    // Golden product with plain integer arithmetic, truncated to 17 bits.
    function automatic logic [16:0] gold(input logic [7:0] x, input logic [7:0] y, input logic xs, input logic ys);
        int xi, yi, p;
        xi = xs ? int'($signed(x)) : int'(x);
        yi = ys ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return 17'(p);
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic clear_run(input int k);
        acc_n[k] = 0;
        last_e[k] = 0;
        qe[k].delete();
        qx[k].delete();
        qr[k].delete();
        qa[k].delete();
        qw[k].delete();
    endtask

    // Model reaction to the inputs present at edge e.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit          dprev;
            logic [16:0] x, r;
            dprev = run_on[k] && acc_n[k] == num_of(k) && last_e[k] + lat_of(k) <= e - 1;
            if (!rst_n) begin
                run_on[k] = 1'b0;
                clear_run(k);
            end else if (st[k] && (!run_on[k] || dprev)) begin
                run_on[k] = 1'b1;
                clear_run(k);
            end else if (run_on[k] && acc_n[k] < num_of(k) && vld[k]) begin
                x = gold(a[k], w[k], sa[k], sw[k]);
                r = force_q[k] ? force_v[k] :
                    ($urandom_range(99) < pct[k]) ? x ^ 17'(1 + $urandom_range(1000)) : x;
                force_q[k] = 1'b0;
                qe[k].push_back(e);
                qx[k].push_back(x);
                qr[k].push_back(r);
                qa[k].push_back(a[k]);
                qw[k].push_back(w[k]);
                acc_n[k]++;
                last_e[k] = e;
            end
        end
    endtask

    // Present the result due at the next edge; garbage when nothing is due.
    task automatic drive_results();
        for (int k = 0; k < 2; k++) begin
            dq[k] = 17'($urandom);
            for (int i = 0; i < qe[k].size(); i++)
                if (qe[k][i] == e + 1 - lat_of(k)) dq[k] = qr[k][i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_update();
        #1;
        drive_results();
    endtask

    task automatic expect_k(input int k, output int c, output int er, output bit dn, output int fi);
        c = 0;
        er = 0;
        fi = -1;
        for (int i = 0; i < qe[k].size(); i++) begin
            if (qe[k][i] + lat_of(k) <= e) begin
                c++;
                if (qr[k][i] != qx[k][i]) begin
                    er++;
                    if (fi < 0) fi = i;
                end
            end
        end
        dn = run_on[k] && acc_n[k] == num_of(k) && last_e[k] + lat_of(k) <= e;
    endtask

    always @(negedge clk) begin
        if (e > 0) begin
            for (int k = 0; k < 2; k++) begin
                int          c, er, fi;
                bit          dn;
                bit          ev;
                logic [7:0]  ea, ew;
                logic [16:0] ex, ec;
                expect_k(k, c, er, dn, fi);
                check("busy", k, 32'(busy[k]), 32'(run_on[k] && !dn));
                check("done", k, 32'(done[k]), 32'(dn));
                check("pass", k, 32'(pass[k]), 32'(dn && er == 0));
                check("chk_cnt", k, chk[k], 32'(c));
                check("err_cnt", k, 32'(err[k]), 32'(er));
                ev = 1'b0;
                ea = '0;
                ew = '0;
                ex = '0;
                ec = '0;
`ifdef MAC_CHK_CAPTURE_EN
                if (fi >= 0) begin
                    ev = 1'b1;
                    ea = qa[k][fi];
                    ew = qw[k][fi];
                    ex = qx[k][fi];
                    ec = qr[k][fi];
                end
`endif
                check("cap_valid", k, 32'(capv[k]), 32'(ev));
                check("cap_a", k, 32'(capa[k]), 32'(ea));
                check("cap_w", k, 32'(capw[k]), 32'(ew));
                check("cap_exp", k, 32'(cape[k]), 32'(ex));
                check("cap_act", k, 32'(capc[k]), 32'(ec));
            end
        end
    end

    task automatic pair(input int k, input logic [7:0] x, input logic [7:0] y, input logic xs, input logic ys);
        vld[k] = 1'b1;
        a[k] = x;
        w[k] = y;
        sa[k] = xs;
        sw[k] = ys;
        step();
        vld[k] = 1'b0;
    endtask

    task automatic start_run(input int k, input logic v);
        st[k] = 1'b1;
        vld[k] = v;
        step();
        st[k] = 1'b0;
        vld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget && !done[k]; i++) step();
        check("done_timeout", k, 32'(done[k]), 32'd1);
    endtask

    initial begin
        int acc5, de;
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; vld[k] = 0; sa[k] = 0; sw[k] = 0;
            a[k] = 0; w[k] = 0; dq[k] = 0;
            run_on[k] = 0; pct[k] = 0; force_q[k] = 0; force_v[k] = 0;
            clear_run(k);
        end

        // reset for two cycles
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_busy", 0, 32'(busy[0]), 32'd0);
        check("rst_done", 1, 32'(done[1]), 32'd0);
        check("rst_chk", 0, chk[0], 32'd0);
        rst_n = 1'b1;
        step();

        // model pins
        check("gold_ss", 0, 32'(gold(8'h80, 8'h80, 1'b1, 1'b1)), 32'd16384);
        check("gold_uu", 0, 32'(gold(8'hFF, 8'hFF, 1'b0, 1'b0)), 32'd65025);
        check("gold_su", 0, 32'(gold(8'hFF, 8'hFF, 1'b1, 1'b0)), 32'h1FF01);
        check("gold_neg", 0, 32'(gold(8'hFD, 8'h07, 1'b1, 1'b1)), 32'h1FFEB);

        // clean signed run, LAT=1 NUM=4
        start_run(0, 1'b0);
        pair(0, 8'h80, 8'h80, 1, 1);
        pair(0, 8'h7F, 8'hFF, 1, 1);
        pair(0, 8'h00, 8'h05, 1, 1);
        pair(0, 8'hFD, 8'h07, 1, 1);
        wait_done(0, 10);
        @(negedge clk);
        check("clean_chk", 0, chk[0], 32'd4);
        check("clean_err", 0, 32'(err[0]), 32'd0);
        check("clean_pass", 0, 32'(pass[0]), 32'd1);

        // single error then a mixed-sign match, restart from DONE
        start_run(0, 1'b1);
        force_q[0] = 1'b1;
        force_v[0] = 17'd0;
        pair(0, 8'hFF, 8'hFF, 0, 0);
        pair(0, 8'hFF, 8'hFF, 1, 0);
        pair(0, 8'h12, 8'h34, 0, 1);
        pair(0, 8'hC0, 8'h03, 1, 1);
        wait_done(0, 10);
        @(negedge clk);
        check("err1_err", 0, 32'(err[0]), 32'd1);
        check("err1_pass", 0, 32'(pass[0]), 32'd0);
`ifdef MAC_CHK_CAPTURE_EN
        check("err1_cap_exp", 0, 32'(cape[0]), 32'd65025);
        check("err1_cap_act", 0, 32'(capc[0]), 32'd0);
        check("err1_cap_a", 0, 32'(capa[0]), 32'hFF);
`endif

        // gapped input, LAT=3 NUM=5: done exactly three edges after the 5th accept
        start_run(1, 1'b0);
        acc5 = 0;
        for (int i = 0; i < 5; i++) begin
            pair(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if (i == 4) acc5 = e;
            if (i < 4) step();
        end
        de = -1;
        for (int i = 0; i < 10 && de < 0; i++) begin
            @(negedge clk);
            if (done[1]) de = e;
            step();
        end
        check("done_latency", 1, 32'(de - acc5), 32'd3);

        // restart from DONE clears counters, then reset during DRAIN
        start_run(1, 1'b1);
        @(negedge clk);
        check("restart_chk", 1, chk[1], 32'd0);
        check("restart_busy", 1, 32'(busy[1]), 32'd1);
        for (int i = 0; i < 60 && acc_n[1] < 5; i++) begin
            vld[1] = 1'($urandom);
            a[1] = 8'($urandom);
            w[1] = 8'($urandom);
            step();
        end
        vld[1] = 1'b0;
        check("drain_reached", 1, 32'(acc_n[1]), 32'd5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        check("rst_drain_chk", 1, chk[1], 32'd0);
        check("rst_drain_busy", 1, 32'(busy[1]), 32'd0);
        check("rst_drain_done", 1, 32'(done[1]), 32'd0);

        // randomized runs with occasional corrupted results and stray starts
        for (int r = 0; r < 8; r++) begin
            int k;
            k = r % 2;
            pct[k] = 25;
            start_run(k, 1'($urandom));
            for (int i = 0; i < 200 && !done[k]; i++) begin
                vld[k] = 1'($urandom);
                a[k] = 8'($urandom);
                w[k] = 8'($urandom);
                sa[k] = 1'($urandom);
                sw[k] = 1'($urandom);
                st[k] = ($urandom_range(19) == 0);
                vld[1-k] = 1'($urandom);
                step();
            end
            st[k] = 1'b0;
            vld[0] = 1'b0;
            vld[1] = 1'b0;
            check("rand_done", k, 32'(done[k]), 32'd1);
            step();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mac_checker.md
MAC_CHECKER -- requirements
Module: mac_checker

Interface
REQ-001 Parameter DW, default 8, operand width in bits.
REQ-002 Parameter LAT, default 1, DUT operand-to-result latency in cycles (range 1..8).
REQ-003 Parameter NUM, default 100, number of operand pairs checked per run (1..2^32-1).
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a run; honoured only in IDLE or DONE.
REQ-007 in_valid  input  1  operand pair presented to the DUT this cycle.
REQ-008 in_a, in_w  input  DW each  operands as driven to the DUT.
REQ-009 in_asigned, in_wsigned  input  1 each  operand signedness as driven to the DUT.
REQ-010 dut_q  input  2*DW+1  DUT result.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  valid in DONE; high when err_cnt is 0.
REQ-014 chk_cnt  output  32  results compared this run.
REQ-015 err_cnt  output  16  mismatches this run, saturating at 16'hFFFF.
REQ-016 cap_valid, cap_a, cap_w, cap_exp, cap_act  output  1/DW/DW/2*DW+1/2*DW+1  first-mismatch capture.

Function
REQ-017 FSM states are IDLE, RUN, DRAIN and DONE; the state after reset is IDLE.
REQ-018 IDLE->RUN and DONE->RUN on start; entering RUN clears chk_cnt, err_cnt, the accept counter, the delay line and the capture registers.
REQ-019 In RUN, a pair is accepted when in_valid=1; the in_valid on the cycle start is taken is ignored.
REQ-020 Each accepted pair enters an LAT-stage delay line carrying valid, A, W, Asigned and Wsigned.
REQ-021 The golden value is computed as follows: extend each operand to DW+1 bits (sign-extend if its signed flag is set, else zero-extend), multiply as signed, and keep the low 2*DW+1 bits.
REQ-022 When the delay-line output is valid, compare golden against dut_q in that same cycle; chk_cnt increments by 1, and err_cnt increments by 1 on mismatch (saturating).
REQ-023 After NUM pairs are accepted, RUN->DRAIN; in DRAIN, in_valid is ignored.
REQ-024 DRAIN->DONE on the cycle the last in-flight compare occurs (chk_cnt reaches NUM).
REQ-025 start in RUN or DRAIN is ignored; in_valid in IDLE or DONE is ignored.
REQ-026 pass = done AND (err_cnt == 0); otherwise pass is 0.
REQ-027 The outputs busy, done and pass are registered and reflect the current state only.

Reset
REQ-028 On rst_n=0 at a clock edge: state=IDLE; all counters, delay-line valid bits, busy, done, pass and all cap_* outputs become 0.
REQ-029 A reset mid-run (RUN or DRAIN) abandons the run; no compare occurs on the reset cycle.

Configuration
REQ-030 Macro MAC_CHK_CAPTURE_EN: when defined, the first mismatch of a run loads cap_a, cap_w, cap_exp (golden) and cap_act (dut_q) and sets cap_valid; later mismatches do not overwrite them.
REQ-031 When MAC_CHK_CAPTURE_EN is undefined, all cap_* outputs are constant 0 and no capture registers exist.

Structure
REQ-032 Package mac_pkg holds the state enum, the golden-multiply function and the result-width constant (2*DW+1).
REQ-033 Sub-module mac_chk_delay implements the parameterised LAT-stage valid/data delay line.

Verification
REQ-034 Test reset: rst_n=0 for 2 cycles -> state IDLE, all outputs 0.
REQ-035 Test a clean run: LAT=1, NUM=4, signed*signed pairs (-128*-128), (127*-1), (0*5), (-3*7) with the correct dut_q values -> after the 4th compare, done=1, pass=1, chk_cnt=4, err_cnt=0.
REQ-036 Test a single error: unsigned 255*255 with dut_q=0 instead of 65025 -> err_cnt=1, pass=0; with MAC_CHK_CAPTURE_EN, cap_exp=65025, cap_act=0, cap_a=8'hFF.
REQ-037 Test mixed signedness: A=-1 signed, W=255 unsigned -> golden value -255 (17'h1FF01) is accepted as a match.
REQ-038 Test gapped input with LAT=3: in_valid toggling 1/0 for NUM=5 -> DRAIN lasts until the 5th compare; done asserts exactly 3 cycles after the 5th accept.
REQ-039 Test restart and reset: start in DONE -> counters clear and a new run begins; rst_n=0 during DRAIN -> IDLE and no further compares.
